// File: rtl/uart_frame_codec.sv
// Frames payloads as DELIM-run / payload / DELIM-run for a byte-level uart_tx, and
// deframes the byte stream from uart_rx with framing, overflow and inter-byte timeout checks.
module uart_frame_codec #(
   parameter int          MAX_LEN        = 137,
   parameter logic [7:0]  DELIM          = 8'h26,
   parameter int          DELIM_CNT      = 2,
   parameter int          RX_TIMEOUT_CLK = 50_000,
   localparam int         LEN_W          = $clog2(MAX_LEN + 1)
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic [8*MAX_LEN-1:0]   tx_string,
   input  logic [LEN_W-1:0]       tx_length,
   input  logic                   tx_req,
   output logic                   tx_busy,
   output logic                   tx_done,
   output logic                   tx_err,
   output logic [7:0]             byte_tx_data,
   output logic                   byte_tx_req,
   input  logic                   byte_tx_done,
   input  logic [7:0]             byte_rx_data,
   input  logic                   byte_rx_vld,
   output logic [8*MAX_LEN-1:0]   rx_string,
   output logic [LEN_W-1:0]       rx_length,
   output logic                   rx_busy,
   output logic                   rx_done,
   output logic                   rx_err
);

   localparam int              TMR_W = $clog2(RX_TIMEOUT_CLK + 1);
   localparam logic [2:0]      DCNT  = 3'(DELIM_CNT);
   localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);

   typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_BODY, TX_TAIL, TX_DONE} tx_state_t;
   typedef enum logic [1:0] {RX_HUNT, RX_HEAD, RX_BODY, RX_TAIL} rx_state_t;

   tx_state_t              tx_state;
   logic [8*MAX_LEN-1:0]   tx_buf;
   logic [LEN_W-1:0]       tx_len;
   logic [LEN_W-1:0]       tx_rem;
   logic [2:0]             tx_run;

   rx_state_t              rx_state;
   logic [8*MAX_LEN-1:0]   rx_buf;
   logic [LEN_W-1:0]       rx_idx;
   logic [2:0]             rx_run;
   logic [TMR_W-1:0]       rx_timer;
   logic                   rx_is_delim;

   assign tx_busy     = (tx_state != TX_IDLE);
   assign rx_busy     = (rx_state != RX_HUNT);
   assign rx_is_delim = (byte_rx_data == DELIM);

   // Payload is shifted out of the latched copy, so byte 0 is always at the bottom.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_state     <= TX_IDLE;
         tx_buf       <= '0;
         tx_len       <= '0;
         tx_rem       <= '0;
         tx_run       <= '0;
         byte_tx_req  <= 1'b0;
         byte_tx_data <= '0;
         tx_done      <= 1'b0;
         tx_err       <= 1'b0;
      end else begin
         byte_tx_req <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               if (tx_req) begin
                  if (tx_length <= LMAX) begin
                     tx_buf       <= tx_string;
                     tx_len       <= tx_length;
                     tx_run       <= 3'd1;
                     byte_tx_req  <= 1'b1;
                     byte_tx_data <= DELIM;
                     tx_state     <= TX_HEAD;
                  end else begin
                     tx_err <= 1'b1;
                  end
               end
            end
            TX_HEAD: begin
               if (byte_tx_done) begin
                  byte_tx_req <= 1'b1;
                  if (tx_run != DCNT) begin
                     tx_run       <= tx_run + 3'd1;
                     byte_tx_data <= DELIM;
                  end else if (tx_len == '0) begin
                     tx_run       <= 3'd1;
                     byte_tx_data <= DELIM;
                     tx_state     <= TX_TAIL;
                  end else begin
                     byte_tx_data <= tx_buf[7:0];
                     tx_buf       <= tx_buf >> 8;
                     tx_rem       <= tx_len - LEN_W'(1);
                     tx_state     <= TX_BODY;
                  end
               end
            end
            TX_BODY: begin
               if (byte_tx_done) begin
                  byte_tx_req <= 1'b1;
                  if (tx_rem != '0) begin
                     byte_tx_data <= tx_buf[7:0];
                     tx_buf       <= tx_buf >> 8;
                     tx_rem       <= tx_rem - LEN_W'(1);
                  end else begin
                     tx_run       <= 3'd1;
                     byte_tx_data <= DELIM;
                     tx_state     <= TX_TAIL;
                  end
               end
            end
            TX_TAIL: begin
               if (byte_tx_done) begin
                  if (tx_run != DCNT) begin
                     byte_tx_req  <= 1'b1;
                     tx_run       <= tx_run + 3'd1;
                     byte_tx_data <= DELIM;
                  end else begin
                     tx_done  <= 1'b1;
                     tx_state <= TX_DONE;
                  end
               end
            end
            TX_DONE: tx_state <= TX_IDLE;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // A received byte takes priority over a timeout expiring in the same cycle.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_state  <= RX_HUNT;
         rx_buf    <= '0;
         rx_idx    <= '0;
         rx_run    <= '0;
         rx_timer  <= '0;
         rx_string <= '0;
         rx_length <= '0;
         rx_done   <= 1'b0;
         rx_err    <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         rx_err  <= 1'b0;
         if (byte_rx_vld) begin
            rx_timer <= '0;
            case (rx_state)
               RX_HUNT: begin
                  if (rx_is_delim) begin
                     rx_run <= 3'd1;
                     rx_idx <= '0;
                     rx_buf <= '0;
                     if (DELIM_CNT == 1) rx_state <= RX_BODY;
                     else                rx_state <= RX_HEAD;
                  end
               end
               RX_HEAD: begin
                  if (rx_is_delim) begin
                     rx_run <= rx_run + 3'd1;
                     if (rx_run + 3'd1 == DCNT) begin
                        rx_idx   <= '0;
                        rx_buf   <= '0;
                        rx_state <= RX_BODY;
                     end
                  end else begin
                     rx_err   <= 1'b1;
                     rx_state <= RX_HUNT;
                  end
               end
               RX_BODY: begin
                  if (rx_is_delim) begin
                     if (DELIM_CNT == 1) begin
                        rx_string <= rx_buf;
                        rx_length <= rx_idx;
                        rx_done   <= 1'b1;
                        rx_state  <= RX_HUNT;
                     end else begin
                        rx_run   <= 3'd1;
                        rx_state <= RX_TAIL;
                     end
                  end else if (rx_idx == LMAX) begin
                     rx_err   <= 1'b1;
                     rx_state <= RX_HUNT;
                  end else begin
                     rx_buf[8*rx_idx +: 8] <= byte_rx_data;
                     rx_idx                <= rx_idx + LEN_W'(1);
                  end
               end
               RX_TAIL: begin
                  if (rx_is_delim) begin
                     rx_run <= rx_run + 3'd1;
                     if (rx_run + 3'd1 == DCNT) begin
                        rx_string <= rx_buf;
                        rx_length <= rx_idx;
                        rx_done   <= 1'b1;
                        rx_state  <= RX_HUNT;
                     end
                  end else begin
                     rx_err   <= 1'b1;
                     rx_state <= RX_HUNT;
                  end
               end
               default: rx_state <= RX_HUNT;
            endcase
         end else if (rx_state != RX_HUNT) begin
            if (rx_timer == TMR_W'(RX_TIMEOUT_CLK - 1)) begin
               rx_err   <= 1'b1;
               rx_timer <= '0;
               rx_state <= RX_HUNT;
            end else begin
               rx_timer <= rx_timer + TMR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_codec.sv
// Scoreboard bench for uart_frame_codec: stimulus pushes expected bytes/events, monitors pop and compare.
module tb_uart_frame_codec;
   localparam int MAX_LEN = 137;
   localparam int LEN_W   = 8;
   localparam int SW      = 8 * MAX_LEN;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n = 1'b0;
   logic [SW-1:0]     tx_string = '0;
   logic [LEN_W-1:0]  tx_length = '0;
   logic              tx_req = 1'b0;
   logic              tx_busy, tx_done, tx_err;
   logic [7:0]        byte_tx_data;
   logic              byte_tx_req;
   logic              byte_tx_done = 1'b0;
   logic [7:0]        byte_rx_data = '0;
   logic              byte_rx_vld = 1'b0;
   logic [SW-1:0]     rx_string;
   logic [LEN_W-1:0]  rx_length;
   logic              rx_busy, rx_done, rx_err;

   uart_frame_codec dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .tx_string(tx_string), .tx_length(tx_length), .tx_req(tx_req),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
      .byte_tx_data(byte_tx_data), .byte_tx_req(byte_tx_req), .byte_tx_done(byte_tx_done),
      .byte_rx_data(byte_rx_data), .byte_rx_vld(byte_rx_vld),
      .rx_string(rx_string), .rx_length(rx_length),
      .rx_busy(rx_busy), .rx_done(rx_done), .rx_err(rx_err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit               err;
      logic [LEN_W-1:0] len;
      logic [SW-1:0]    str;
   } rx_exp_t;

   logic [7:0]       exp_tx_q[$];
   int               exp_txdone_q[$];
   int               exp_txerr_q[$];
   rx_exp_t          exp_rx_q[$];
   logic [LEN_W-1:0] last_len = '0;
   logic [SW-1:0]    last_str = '0;
   int               n_checks = 0;
   int               n_errs = 0;

   task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Byte-level uart_tx stand-in: answers each strobe with byte_tx_done a few cycles later.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (byte_tx_req && sys_rst_n) begin
            repeat (2) @(posedge sys_clk);
            #1 byte_tx_done = 1'b1;
            @(posedge sys_clk);
            #1 byte_tx_done = 1'b0;
         end
      end
   end

   always @(negedge sys_clk) begin : tx_monitor
      logic [7:0] e;
      if (sys_rst_n) begin
         if (byte_tx_req) begin
            if (exp_tx_q.size() == 0) check("tx_unexpected_byte", 1'b0, 64'(byte_tx_data), 64'h0);
            else begin
               e = exp_tx_q.pop_front();
               check("tx_byte", byte_tx_data == e, 64'(byte_tx_data), 64'(e));
               check("tx_busy_in_frame", tx_busy == 1'b1, 64'(tx_busy), 64'h1);
            end
         end
         if (tx_done) begin
            if (exp_txdone_q.size() == 0) check("tx_done_unexpected", 1'b0, 64'h1, 64'h0);
            else begin
               void'(exp_txdone_q.pop_front());
               check("tx_done_after_last_byte", exp_tx_q.size() == 0, 64'(exp_tx_q.size()), 64'h0);
            end
         end
         if (tx_err) begin
            if (exp_txerr_q.size() == 0) check("tx_err_unexpected", 1'b0, 64'h1, 64'h0);
            else begin
               void'(exp_txerr_q.pop_front());
               check("tx_err_idle", tx_busy == 1'b0, 64'(tx_busy), 64'h0);
            end
         end
      end
   end

   always @(negedge sys_clk) begin : rx_monitor
      rx_exp_t r;
      if (sys_rst_n && (rx_done || rx_err)) begin
         if (exp_rx_q.size() == 0) check("rx_event_unexpected", 1'b0, {62'h0, rx_err, rx_done}, 64'h0);
         else begin
            r = exp_rx_q.pop_front();
            check("rx_event_kind", rx_err == r.err && rx_done == !r.err, {62'h0, rx_err, rx_done}, {62'h0, r.err, !r.err});
            check("rx_length", rx_length == r.len, 64'(rx_length), 64'(r.len));
            check("rx_string", rx_string == r.str, rx_string[63:0], r.str[63:0]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_tx(input logic [SW-1:0] s, input int len);
      @(posedge sys_clk);
      #1 tx_string = s; tx_length = LEN_W'(len); tx_req = 1'b1;
      @(posedge sys_clk);
      #1 tx_req = 1'b0;
   endtask

   task automatic push_frame(input logic [SW-1:0] s, input int len);
      exp_tx_q.push_back(8'h26); exp_tx_q.push_back(8'h26);
      for (int i = 0; i < len; i++) exp_tx_q.push_back(s[8*i +: 8]);
      exp_tx_q.push_back(8'h26); exp_tx_q.push_back(8'h26);
      exp_txdone_q.push_back(1);
   endtask

   task automatic wait_tx_idle(input string name);
      int c = 0;
      while ((tx_busy || exp_tx_q.size() != 0 || exp_txdone_q.size() != 0 || exp_txerr_q.size() != 0) && c < 5000) begin
         @(posedge sys_clk);
         c++;
      end
      #1;
      check(name, c < 5000, 64'(c), 64'd5000);
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(posedge sys_clk);
      #1 byte_rx_data = b; byte_rx_vld = 1'b1;
      @(posedge sys_clk);
      #1 byte_rx_vld = 1'b0;
   endtask

   task automatic expect_rx_done(input int len, input logic [SW-1:0] s);
      exp_rx_q.push_back('{err: 1'b0, len: LEN_W'(len), str: s});
      last_len = LEN_W'(len);
      last_str = s;
   endtask

   task automatic expect_rx_err();
      exp_rx_q.push_back('{err: 1'b1, len: last_len, str: last_str});
   endtask

   task automatic wait_rx_drain(input string name, input int bound);
      int c = 0;
      while (exp_rx_q.size() != 0 && c < bound) begin
         @(posedge sys_clk);
         c++;
      end
      tick(2);
      check(name, exp_rx_q.size() == 0, 64'(exp_rx_q.size()), 64'h0);
   endtask

   initial begin
      logic [SW-1:0] s;
      logic [7:0]    b;
      int            c;

      tick(3);
      check("rst_tx_busy", tx_busy == 1'b0, 64'(tx_busy), 64'h0);
      check("rst_byte_tx_req", byte_tx_req == 1'b0, 64'(byte_tx_req), 64'h0);
      check("rst_byte_tx_data", byte_tx_data == 8'h0, 64'(byte_tx_data), 64'h0);
      check("rst_tx_pulses", {tx_done, tx_err} == 2'b00, 64'({tx_done, tx_err}), 64'h0);
      check("rst_rx_flags", {rx_busy, rx_done, rx_err} == 3'b000, 64'({rx_busy, rx_done, rx_err}), 64'h0);
      check("rst_rx_length", rx_length == '0, 64'(rx_length), 64'h0);
      check("rst_rx_string", rx_string == '0, rx_string[63:0], 64'h0);
      sys_rst_n = 1'b1;
      tick(2);

      // "ABC", then the source is scribbled and a second request is fired mid-frame.
      s = '0; s[23:0] = 24'h434241;
      push_frame(s, 3);
      send_tx(s, 3);
      tx_string = '1; tx_length = 8'd1;
      tick(5);
      check("tx_busy_mid_frame", tx_busy == 1'b1, 64'(tx_busy), 64'h1);
      tx_req = 1'b1; tick(1); tx_req = 1'b0;
      wait_tx_idle("tx_abc_complete");

      push_frame('0, 0);
      send_tx('0, 0);
      wait_tx_idle("tx_zero_len_complete");

      exp_txerr_q.push_back(1);
      send_tx('1, 138);
      tick(3);
      check("tx_reject_no_busy", tx_busy == 1'b0, 64'(tx_busy), 64'h0);
      wait_tx_idle("tx_reject_complete");

      // Leading junk byte, then "Hi".
      send_rx(8'h55); send_rx(8'h26); send_rx(8'h26); send_rx(8'h48); send_rx(8'h69); send_rx(8'h26);
      s = '0; s[15:0] = 16'h6948;
      expect_rx_done(2, s);
      send_rx(8'h26);
      wait_rx_drain("rx_hi_frame", 50);

      send_rx(8'h26); send_rx(8'h26); send_rx(8'h41); send_rx(8'h26);
      expect_rx_err();
      send_rx(8'h42);
      wait_rx_drain("rx_bad_trailer", 50);

      // Full-size payload is legal.
      s = '0;
      send_rx(8'h26); send_rx(8'h26);
      for (int i = 0; i < MAX_LEN; i++) begin
         b = 8'h30 + 8'(i % 10);
         s[8*i +: 8] = b;
         send_rx(b);
      end
      send_rx(8'h26);
      expect_rx_done(MAX_LEN, s);
      send_rx(8'h26);
      wait_rx_drain("rx_max_len_frame", 50);

      send_rx(8'h26); send_rx(8'h26);
      for (int i = 0; i < MAX_LEN; i++) send_rx(8'h61 + 8'(i % 20));
      expect_rx_err();
      send_rx(8'h7E);
      wait_rx_drain("rx_overflow", 50);

      s = '0; s[23:0] = 24'h7A7978;
      send_rx(8'h26); send_rx(8'h26); send_rx(8'h78); send_rx(8'h79); send_rx(8'h7A); send_rx(8'h26);
      expect_rx_done(3, s);
      send_rx(8'h26);
      wait_rx_drain("rx_after_overflow", 50);

      send_rx(8'h26); send_rx(8'h26); send_rx(8'h26);
      expect_rx_done(0, '0);
      send_rx(8'h26);
      wait_rx_drain("rx_zero_len", 50);

      send_rx(8'h26); send_rx(8'h26); send_rx(8'h41);
      expect_rx_err();
      c = 0;
      while (!rx_err && c < 50_100) begin
         @(negedge sys_clk);
         c++;
      end
      check("rx_timeout_latency", c >= 49_990 && c <= 50_010, 64'(c), 64'd50_000);
      wait_rx_drain("rx_timeout", 10);

      // TX and RX side by side.
      fork
         begin
            logic [SW-1:0] ts;
            ts = '0; ts[15:0] = 16'h5A59;
            push_frame(ts, 2);
            send_tx(ts, 2);
            wait_tx_idle("concurrent_tx");
         end
         begin
            logic [SW-1:0] rs;
            rs = '0; rs[7:0] = 8'h51;
            send_rx(8'h26); send_rx(8'h26); send_rx(8'h51); send_rx(8'h26);
            expect_rx_done(1, rs);
            send_rx(8'h26);
            wait_rx_drain("concurrent_rx", 50);
         end
      join

      // Reset part-way through a frame: nothing more may come out.
      s = '0; s[23:0] = 24'h434241;
      push_frame(s, 3);
      send_tx(s, 3);
      c = 0;
      while (exp_tx_q.size() > 4 && c < 2000) begin
         @(posedge sys_clk);
         c++;
      end
      check("mid_tx_progress", c < 2000, 64'(c), 64'd2000);
      #2 sys_rst_n = 1'b0;
      #1;
      check("mid_rst_byte_tx_req", byte_tx_req == 1'b0, 64'(byte_tx_req), 64'h0);
      check("mid_rst_tx_busy", tx_busy == 1'b0, 64'(tx_busy), 64'h0);
      check("mid_rst_rx_length", rx_length == '0, 64'(rx_length), 64'h0);
      exp_tx_q.delete();
      exp_txdone_q.delete();
      last_len = '0;
      last_str = '0;
      tick(2);
      sys_rst_n = 1'b1;
      tick(30);
      check("post_rst_tx_idle", tx_busy == 1'b0, 64'(tx_busy), 64'h0);

      check("tx_queue_empty", exp_tx_q.size() == 0, 64'(exp_tx_q.size()), 64'h0);
      check("rx_queue_empty", exp_rx_q.size() == 0, 64'(exp_rx_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_frame_codec.md
UART_FRAME_CODEC -- requirements
Module: uart_frame_codec

Interface
REQ-001 SHALL have parameter MAX_LEN, default 137, maximum payload bytes per frame.
REQ-002 SHALL have parameter DELIM, default 8'h26 ("&"), frame delimiter byte.
REQ-003 SHALL have parameter DELIM_CNT, default 2, range 1..4, delimiter bytes in each header and each trailer.
REQ-004 SHALL have parameter RX_TIMEOUT_CLK, default 50_000, maximum clocks allowed between received bytes inside a frame.
REQ-005 SHALL have derived localparam LEN_W = $clog2(MAX_LEN+1).
REQ-006 sys_clk  in  1  clock; all logic on the rising edge.
REQ-007 sys_rst_n  in  1  reset; asynchronous, active-low.
REQ-008 tx_string  in  8*MAX_LEN  payload; byte k in bits [8k+7:8k].
REQ-009 tx_length  in  LEN_W  payload byte count.
REQ-010 tx_req  in  1  start request; sampled only in TX_IDLE.
REQ-011 tx_busy  out  1  high while the TX FSM is not in TX_IDLE.
REQ-012 tx_done  out  1  one-cycle pulse when a frame completes.
REQ-013 tx_err  out  1  one-cycle pulse when a request is rejected.
REQ-014 byte_tx_data  out  8  byte to the existing uart_tx.
REQ-015 byte_tx_req  out  1  one-cycle strobe to the existing uart_tx.
REQ-016 byte_tx_done  in  1  one-cycle pulse from uart_tx when a byte is sent.
REQ-017 byte_rx_data  in  8  byte from the existing uart_rx.
REQ-018 byte_rx_vld  in  1  one-cycle strobe from uart_rx; byte_rx_data is valid in that cycle.
REQ-019 rx_string  out  8*MAX_LEN  received payload, same byte packing as tx_string.
REQ-020 rx_length  out  LEN_W  received payload byte count.
REQ-021 rx_busy  out  1  high in RX_HEAD, RX_BODY and RX_TAIL.
REQ-022 rx_done  out  1  one-cycle pulse when a valid frame is received.
REQ-023 rx_err  out  1  one-cycle pulse on a framing error, overflow or timeout.

Function
REQ-024 Wire frame format SHALL be DELIM_CNT×DELIM, then payload, then DELIM_CNT×DELIM.
REQ-025 Payload SHALL NOT contain DELIM; any DELIM received in RX_BODY begins the trailer.
REQ-026 TX FSM SHALL have states TX_IDLE, TX_HEAD, TX_BODY, TX_TAIL, TX_DONE.
REQ-027 In TX_IDLE with tx_req and tx_length≤MAX_LEN, the FSM SHALL latch tx_string and tx_length, enter TX_HEAD, and assert byte_tx_req=1 with byte_tx_data=DELIM on the next cycle.
REQ-028 In TX_IDLE with tx_req and tx_length>MAX_LEN, the FSM SHALL stay in TX_IDLE, pulse tx_err for one cycle, and send no bytes.
REQ-029 The TX FSM SHALL issue each further byte_tx_req exactly one cycle after the byte_tx_done of the previous byte; only one byte is ever outstanding.
REQ-030 TX_HEAD SHALL send DELIM_CNT delimiters, then go to TX_BODY, or straight to TX_TAIL when the latched length is 0.
REQ-031 TX_BODY SHALL send latched payload bytes 0..len-1 in ascending order.
REQ-032 TX_TAIL SHALL send DELIM_CNT delimiters.
REQ-033 After the final byte_tx_done, the FSM SHALL enter TX_DONE, pulse tx_done, and return to TX_IDLE on the next cycle.
REQ-034 tx_req while tx_busy SHALL be ignored.
REQ-035 Changes to tx_string or tx_length after acceptance SHALL NOT affect the frame in flight.
REQ-036 RX FSM SHALL have states RX_HUNT, RX_HEAD, RX_BODY, RX_TAIL.
REQ-037 In RX_HUNT, a DELIM byte SHALL set the delimiter-run count to 1 and the FSM SHALL enter RX_HEAD; with DELIM_CNT=1 it enters RX_BODY directly.
REQ-038 Non-DELIM bytes in RX_HUNT SHALL be discarded silently.
REQ-039 In RX_HEAD, each DELIM SHALL increment the run count until it equals DELIM_CNT, then the FSM enters RX_BODY with the write index at 0.
REQ-040 In RX_HEAD, a non-DELIM byte SHALL pulse rx_err and return the FSM to RX_HUNT.
REQ-041 In RX_BODY, a non-DELIM byte SHALL be written at the write index and the index incremented.
REQ-042 A byte arriving in RX_BODY when the index already equals MAX_LEN SHALL pulse rx_err and return the FSM to RX_HUNT.
REQ-043 A DELIM in RX_BODY SHALL start the trailer run: count=1, enter RX_TAIL.
REQ-044 In RX_TAIL, a non-DELIM byte before the run reaches DELIM_CNT SHALL pulse rx_err and return the FSM to RX_HUNT.
REQ-045 When the trailer run reaches DELIM_CNT, the block SHALL update rx_length to the index and rx_string to the buffer contents, pulse rx_done in the following cycle, and return to RX_HUNT.
REQ-046 rx_string and rx_length SHALL change only on rx_done; their values are held between frames.
REQ-047 The payload buffer SHALL be separate from rx_string, or rx_string SHALL be double-buffered.
REQ-048 Zero-length frames SHALL be legal: rx_done with rx_length=0.
REQ-049 An inter-byte timer SHALL count clocks in RX_HEAD, RX_BODY and RX_TAIL and clear on each byte_rx_vld.
REQ-050 When the timer reaches RX_TIMEOUT_CLK, the block SHALL pulse rx_err and return the FSM to RX_HUNT.
REQ-051 If a byte_rx_vld and the timeout occur in the same cycle, the byte SHALL win.
REQ-052 TX and RX SHALL operate fully concurrently.

Reset
REQ-053 On reset: both FSMs SHALL go to idle/hunt; all counters and timers SHALL clear to 0; tx_busy, tx_done, tx_err, byte_tx_req, rx_busy, rx_done and rx_err SHALL be 0; byte_tx_data, rx_string and rx_length SHALL be 0.
REQ-054 Reset mid-frame SHALL abort the frame without any done or err pulse.

Verification
REQ-055 tx_req with length=3 and "ABC" (defaults) -> byte sequence 26 26 41 42 43 26 26; one tx_done pulse; tx_busy is high for the whole frame.
REQ-056 tx_req with tx_length=0 -> bytes 26 26 26 26, then tx_done; tx_req with tx_length=138 -> tx_err pulse and no byte_tx_req.
REQ-057 RX input 55 26 26 48 69 26 26 -> rx_done pulse; rx_length=2; rx_string[15:0]=16'h6948.
REQ-058 RX input 26 26 41 26 42 -> rx_err pulse at byte 42; rx_string and rx_length unchanged.
REQ-059 RX input of 138 payload bytes -> rx_err pulse on byte 138; a following valid frame decodes correctly.
REQ-060 RX input 26 26 41, then 50_000 idle clocks -> rx_err pulse; separately, reset asserted mid-TX -> byte_tx_req=0 and no tx_done.
